// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_ctrl_pkg: shared encodings and constants for the pipeline controller  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    REDIRECT = 2'd2
  } state_e;

  localparam logic [4:0] c_reg_x0          = 5'd0;
  localparam int         c_timeout_default = 64;

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hazard_detect: load-use comparator between ID/EX load and IF/ID sources    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       idex_memread,
  input  logic [4:0] idex_rd,
  input  logic [4:0] ifid_rs1,
  input  logic [4:0] ifid_rs2,
  input  logic       ifid_use_rs1,
  input  logic       ifid_use_rs2,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = ifid_use_rs1 & (ifid_rs1 == idex_rd);
  assign rs2_hit  = ifid_use_rs2 & (ifid_rs2 == idex_rd);
  // x0 is never really written, so a load into it cannot create a hazard
  assign load_use = idex_memread & (idex_rd != c_reg_x0) & (rs1_hit | rs2_hit);

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipeline_hazard_ctrl: stall/flush sequencer with perf counters and timeout |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = c_timeout_default,
  parameter int TO_W    = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rd,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             ifid_use_rs1,
  input  logic             ifid_use_rs2,
  input  logic             exmem_redirect,
  input  logic             exmem_memreq,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             pc_sel_redirect,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout_err
);

  localparam logic [TO_W-1:0] c_to_limit = TO_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic [TO_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             err_q, err_d;

  logic load_use;
  logic ev_mem_stall;
  logic ev_redirect;
  logic ev_load_use;

  hazard_detect u_hazard_detect (
    .idex_memread (idex_memread),
    .idex_rd      (idex_rd),
    .ifid_rs1     (ifid_rs1),
    .ifid_rs2     (ifid_rs2),
    .ifid_use_rs1 (ifid_use_rs1),
    .ifid_use_rs2 (ifid_use_rs2),
    .load_use     (load_use)
  );

  // In REDIRECT the younger stages hold killed bubbles, so no event can be real
  assign ev_mem_stall = exmem_memreq & ~dmem_ready & (state_q != REDIRECT);
  assign ev_redirect  = exmem_redirect & (state_q != REDIRECT);
  assign ev_load_use  = load_use & (state_q != REDIRECT);

  always_comb begin
    pc_en           = 1'b1;
    pc_sel_redirect = 1'b0;
    ifid_en         = 1'b1;
    idex_en         = 1'b1;
    exmem_en        = 1'b1;
    memwb_en        = 1'b1;
    ifid_flush      = 1'b0;
    idex_flush      = 1'b0;
    exmem_flush     = 1'b0;
    if (ev_mem_stall) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (ev_redirect) begin
      pc_sel_redirect = 1'b1;
      ifid_flush      = 1'b1;
      idex_flush      = 1'b1;
      exmem_flush     = 1'b1;
    end else if (ev_load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    err_d       = err_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      RUN: begin
        if (ev_mem_stall) begin
          state_d = MEM_WAIT;
          wait_d  = TO_W'(1);
        end else if (ev_redirect) begin
          state_d = REDIRECT;
        end
      end
      MEM_WAIT: begin
        if (ev_mem_stall) begin
          if (wait_q != c_to_limit) wait_d = wait_q + TO_W'(1);
        end else begin
          state_d = ev_redirect ? REDIRECT : RUN;
          wait_d  = '0;
        end
      end
      REDIRECT: state_d = RUN;
      default:  state_d = RUN;
    endcase
    // The access is never aborted; the error only reports a slow memory
    if ((state_d == MEM_WAIT) && (wait_d == c_to_limit)) err_d = 1'b1;
    if (!pc_en && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (pc_sel_redirect && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      wait_q      <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign state           = state_q;
  assign stall_cnt       = stall_cnt_q;
  assign flush_cnt       = flush_cnt_q;
  assign mem_timeout_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pipeline_hazard_ctrl: directed stimulus with a queued expected response |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;
  localparam int TO_W    = 7;

  // {pc_en, pc_sel, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, exmem_fl}
  localparam logic [8:0] IDLE = 9'b1_0_1111_000;
  localparam logic [8:0] LU   = 9'b0_0_0111_010;
  localparam logic [8:0] RD   = 9'b1_1_1111_111;
  localparam logic [8:0] FRZ  = 9'b0_0_0000_000;
  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_MW  = 2'd1;
  localparam logic [1:0] S_RD  = 2'd2;

  typedef struct {
    string      name;
    logic [8:0] ctl;
    logic [1:0] st;
    int         sc;
    int         fc;
    logic       err;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             idex_memread = 1'b0;
  logic [4:0]       idex_rd = '0;
  logic [4:0]       ifid_rs1 = '0;
  logic [4:0]       ifid_rs2 = '0;
  logic             ifid_use_rs1 = 1'b0;
  logic             ifid_use_rs2 = 1'b0;
  logic             exmem_redirect = 1'b0;
  logic             exmem_memreq = 1'b0;
  logic             dmem_ready = 1'b0;
  logic             pc_en, pc_sel_redirect, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush, exmem_flush;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             mem_timeout_err;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .idex_memread    (idex_memread),
    .idex_rd         (idex_rd),
    .ifid_rs1        (ifid_rs1),
    .ifid_rs2        (ifid_rs2),
    .ifid_use_rs1    (ifid_use_rs1),
    .ifid_use_rs2    (ifid_use_rs2),
    .exmem_redirect  (exmem_redirect),
    .exmem_memreq    (exmem_memreq),
    .dmem_ready      (dmem_ready),
    .pc_en           (pc_en),
    .pc_sel_redirect (pc_sel_redirect),
    .ifid_en         (ifid_en),
    .idex_en         (idex_en),
    .exmem_en        (exmem_en),
    .memwb_en        (memwb_en),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .exmem_flush     (exmem_flush),
    .state           (state),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt),
    .mem_timeout_err (mem_timeout_err)
  );

  // Inputs change just after the active (falling) edge; expectations are queued with them
  task automatic cyc(input string nm, input logic rst_n,
                     input logic mr, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic redir, input logic mreq, input logic rdy,
                     input logic [8:0] ctl, input logic [1:0] st, input int sc, input int fc, input logic err);
    exp_t e;
    @(negedge clk);
    #1;
    reset          = rst_n;
    idex_memread   = mr;
    idex_rd        = rd;
    ifid_rs1       = rs1;
    ifid_rs2       = rs2;
    ifid_use_rs1   = u1;
    ifid_use_rs2   = u2;
    exmem_redirect = redir;
    exmem_memreq   = mreq;
    dmem_ready     = rdy;
    e.name = nm; e.ctl = ctl; e.st = st; e.sc = sc; e.fc = fc; e.err = err;
    sb.push_back(e);
  endtask

  // Monitor: the DUT presents a fresh output every cycle, sampled mid-cycle
  initial begin
    exp_t       e;
    logic [8:0] act;
    forever begin
      @(posedge clk);
      if (sb.size() != 0) begin
        e   = sb.pop_front();
        act = {pc_en, pc_sel_redirect, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush};
        n_tests++;
        if (act !== e.ctl || state !== e.st || int'(stall_cnt) != e.sc ||
            int'(flush_cnt) != e.fc || mem_timeout_err !== e.err) begin
          n_fail++;
          $display("FAIL %s: got ctl=%b st=%0d stall=%0d flush=%0d err=%b, want ctl=%b st=%0d stall=%0d flush=%0d err=%b",
                   e.name, act, state, stall_cnt, flush_cnt, mem_timeout_err,
                   e.ctl, e.st, e.sc, e.fc, e.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset, load-use, x0 and use-flag boundaries
    cyc("reset",       0, 0,0,0,0,0,0, 0,0,0, IDLE, S_RUN, 0,0,0);
    cyc("lu_rs1",      1, 1,5,5,1,1,0, 0,0,0, LU,   S_RUN, 0,0,0);
    cyc("lu_after",    1, 0,0,0,0,0,0, 0,0,0, IDLE, S_RUN, 1,0,0);
    cyc("lu_rd_x0",    1, 1,0,0,0,1,0, 0,0,0, IDLE, S_RUN, 1,0,0);
    cyc("lu_rs2",      1, 1,7,3,7,1,1, 0,0,0, LU,   S_RUN, 1,0,0);
    cyc("lu_no_use",   1, 1,7,3,7,1,0, 0,0,0, IDLE, S_RUN, 2,0,0);
    // redirect, load_use suppressed in REDIRECT, redirect beats load_use
    cyc("redir",       1, 0,0,0,0,0,0, 1,0,0, RD,   S_RUN, 2,0,0);
    cyc("redir_st",    1, 1,5,5,1,1,0, 0,0,0, IDLE, S_RD,  2,1,0);
    cyc("redir_back",  1, 0,0,0,0,0,0, 0,0,0, IDLE, S_RUN, 2,1,0);
    cyc("redir_lu",    1, 1,5,5,1,1,0, 1,0,0, RD,   S_RUN, 2,1,0);
    cyc("redir_lu_st", 1, 0,0,0,0,0,0, 0,0,0, IDLE, S_RD,  2,2,0);
    cyc("redir_lu_bk", 1, 0,0,0,0,0,0, 0,0,0, IDLE, S_RUN, 2,2,0);
    // memory wait of three cycles
    cyc("reset2",      0, 0,0,0,0,0,0, 0,0,0, IDLE, S_RUN, 0,0,0);
    cyc("mw1",         1, 0,0,0,0,0,0, 0,1,0, FRZ,  S_RUN, 0,0,0);
    cyc("mw2",         1, 0,0,0,0,0,0, 0,1,0, FRZ,  S_MW,  1,0,0);
    cyc("mw3",         1, 0,0,0,0,0,0, 0,1,0, FRZ,  S_MW,  2,0,0);
    cyc("mw_ready",    1, 0,0,0,0,0,0, 0,1,1, IDLE, S_MW,  3,0,0);
    cyc("mw_done",     1, 0,0,0,0,0,0, 0,0,0, IDLE, S_RUN, 3,0,0);
    // timeout: six wait cycles with TIMEOUT=4
    cyc("to1",         1, 0,0,0,0,0,0, 0,1,0, FRZ,  S_RUN, 3,0,0);
    cyc("to2",         1, 0,0,0,0,0,0, 0,1,0, FRZ,  S_MW,  4,0,0);
    cyc("to3",         1, 0,0,0,0,0,0, 0,1,0, FRZ,  S_MW,  5,0,0);
    cyc("to4",         1, 0,0,0,0,0,0, 0,1,0, FRZ,  S_MW,  6,0,0);
    cyc("to5_err",     1, 0,0,0,0,0,0, 0,1,0, FRZ,  S_MW,  7,0,1);
    cyc("to6",         1, 0,0,0,0,0,0, 0,1,0, FRZ,  S_MW,  8,0,1);
    cyc("to_ready",    1, 0,0,0,0,0,0, 0,1,1, IDLE, S_MW,  9,0,1);
    cyc("to_sticky",   1, 0,0,0,0,0,0, 0,0,0, IDLE, S_RUN, 9,0,1);
    // asynchronous reset between edges in MEM_WAIT
    cyc("ar_w1",       1, 0,0,0,0,0,0, 0,1,0, FRZ,  S_RUN, 9,0,1);
    cyc("ar_w2",       1, 0,0,0,0,0,0, 0,1,0, FRZ,  S_MW,  10,0,1);
    cyc("ar_reset",    0, 0,0,0,0,0,0, 0,0,0, IDLE, S_RUN, 0,0,0);
    // priority: mem_stall, redirect and load_use together
    cyc("pri_frz1",    1, 1,5,5,1,1,0, 1,1,0, FRZ,  S_RUN, 0,0,0);
    cyc("pri_frz2",    1, 1,5,5,1,1,0, 1,1,0, FRZ,  S_MW,  1,0,0);
    cyc("pri_ready",   1, 1,5,5,1,1,0, 1,1,1, RD,   S_MW,  2,0,0);
    cyc("pri_redir",   1, 0,0,0,0,0,0, 0,0,0, IDLE, S_RD,  2,1,0);
    cyc("pri_back",    1, 0,0,0,0,0,0, 0,0,0, IDLE, S_RUN, 2,1,0);
    // stall counter saturates at all-ones (CNT_W=4)
    for (int i = 0; i < 15; i++)
      cyc("sat_frz", 1, 0,0,0,0,0,0, 0,1,0, FRZ, (i == 0) ? S_RUN : S_MW,
          (2 + i > 15) ? 15 : 2 + i, 1, (i >= 4) ? 1'b1 : 1'b0);
    cyc("sat_ready",   1, 0,0,0,0,0,0, 0,1,1, IDLE, S_MW,  15,1,1);
    cyc("sat_hold",    1, 0,0,0,0,0,0, 0,0,0, IDLE, S_RUN, 15,1,1);

    for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expected responses left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Drives enable and flush of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers from three event sources:
  - load-use hazards;
  - control redirects resolved in MEM (branch/jal/jalr);
  - the data-memory ready handshake.
- Keeps stall/flush performance counters and a sticky memory-timeout error.
- Sits beside the pipeline registers; purely a control block, no datapath.

Parameters:
- CNT_W, 16, width of the stall and flush performance counters (saturating).
- TIMEOUT, 64, number of MEM_WAIT cycles after which mem_timeout_err sets.
- TO_W, 7, width of the wait-cycle counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  pipeline clock; all state updates on the falling edge, same as the pipeline registers.
- reset  in  1  reset, asynchronous, active-low.
- idex_memread  in  1  instruction in ID/EX is a load.
- idex_rd  in  5  destination register in ID/EX.
- ifid_rs1, ifid_rs2  in  5 each  source registers of the instruction in IF/ID.
- ifid_use_rs1, ifid_use_rs2  in  1 each  the IF/ID instruction actually reads that source.
- exmem_redirect  in  1  taken branch, jal or jalr in EX/MEM (Orgate | Jalr | jal).
- exmem_memreq  in  1  EX/MEM MemRead | MemWrite.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC write enable.
- pc_sel_redirect  out  1  PC mux selects the EX/MEM target.
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage register enables.
- ifid_flush, idex_flush, exmem_flush  out  1 each  synchronous bubble insert; takes effect only while the matching enable is 1.
- state  out  2  FSM state: RUN=0, MEM_WAIT=1, REDIRECT=2.
- stall_cnt  out  CNT_W  cycles with pc_en=0.
- flush_cnt  out  CNT_W  redirect events.
- mem_timeout_err  out  1  sticky error.

Behaviour:
Reset (reset=0, asynchronous):
- state=RUN; wait counter=0; stall_cnt=0; flush_cnt=0; mem_timeout_err=0.
- Outputs are decoded from state plus inputs. In RUN with no events: all enables=1, all flushes=0, pc_sel_redirect=0.

Event evaluation order is fixed: mem_stall, then redirect, then load_use.
- mem_stall = exmem_memreq & ~dmem_ready.
  - Action: all five enables=0, all flushes=0. The whole pipe freezes.
- redirect = exmem_redirect.
  - Action: pc_sel_redirect=1, pc_en=1, all enables=1.
  - ifid_flush=1, idex_flush=1, exmem_flush=1, which kills the three younger instructions.
- load_use = idex_memread & (idex_rd!=0) & ((ifid_use_rs1 & rs1==rd) | (ifid_use_rs2 & rs2==rd)).
  - Action: pc_en=0, ifid_en=0, idex_flush=1 (inserts one bubble). Other enables=1.

FSM transitions (falling edge):
- RUN:
  - mem_stall: go to MEM_WAIT and load the wait counter with 1.
  - else redirect: go to REDIRECT.
  - else stay in RUN.
- MEM_WAIT:
  - Outputs stay frozen while mem_stall persists.
  - Wait counter increments and saturates at TIMEOUT.
  - When the counter reaches TIMEOUT, mem_timeout_err sets and stays set until reset. The FSM keeps waiting; it never aborts the access.
  - When dmem_ready=1, the access completes and this cycle is evaluated as in RUN (redirect or load_use may act).
  - Next state is REDIRECT if redirect, else RUN. The wait counter clears.
- REDIRECT:
  - One cycle only. load_use is suppressed because the ID/EX instruction is a killed bubble.
  - A new redirect is impossible (EX/MEM was flushed).
  - mem_stall is also impossible for the same reason.
  - Returns to RUN.

Counters:
- stall_cnt increments on every cycle with pc_en=0.
- flush_cnt increments on every cycle with pc_sel_redirect=1.
- Both saturate at all-ones; they do not wrap.

Simultaneous events:
- mem_stall and redirect together: stall wins; the redirect is applied on the ready cycle.
- redirect and load_use together: redirect wins; the offending instruction is flushed anyway.

Reset mid-MEM_WAIT: returns to RUN immediately and clears all counters and the error flag.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state encodings RUN/MEM_WAIT/REDIRECT;
  - the x0 register index constant;
  - the TIMEOUT default.
- One natural sub-module, hazard_detect: combinational load-use comparator producing load_use.
- The FSM and counters stay in the top module.

Test Plan:
- Load-use: lw x5 in ID/EX, add x6,x5,x1 in IF/ID (rs1=5, use_rs1=1).
  - Exactly one cycle with pc_en=0, ifid_en=0, idex_flush=1; stall_cnt 0→1.
  - Repeat with rd=0: no stall.
- Redirect: exmem_redirect=1 for one cycle.
  - pc_sel_redirect=1; ifid/idex/exmem flush=1; state RUN→REDIRECT→RUN; flush_cnt=1.
- Memory wait: exmem_memreq=1, dmem_ready=0 for 3 cycles, then 1.
  - All enables=0 for 3 cycles; state=MEM_WAIT; enables=1 on the ready cycle; stall_cnt=3.
- Timeout: TIMEOUT=4, ready held low for 6 cycles.
  - mem_timeout_err rises on the 4th wait cycle and stays set after ready; cleared only by reset.
- Priority: mem_stall, redirect and load_use all asserted.
  - Freeze first; on the ready cycle redirect flushes and the load_use stall is not applied.
- Async reset asserted mid-MEM_WAIT, between clock edges.
  - Immediate state=RUN; counters=0; error=0; outputs at RUN defaults.
